// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage downstream of the program counter.
//
// Owns the fetch address, issues in-order reads to instruction memory and
// buffers returned words with their addresses in a DEPTH-entry FIFO for
// decode. A redirect reloads the fetch address, empties the FIFO and marks
// every outstanding read as stale so its response is thrown away on arrival.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   halt                blocks new requests (responses/pops/redirects continue)
//   redirect_valid/_pc  branch redirect strobe and target address
//   imem_req_*          read request handshake, imem_addr = fetch address
//   imem_rsp_*          in-order read data return, one per accepted request
//   inst_valid/_ready   instruction handshake towards decode
//   inst_data, inst_pc  FIFO head word and its address (0 while empty)
//   fetch_count         delivered-instruction count (FETCH_STATS_EN only)
//
// Optional feature macro: FETCH_STATS_EN adds the fetch_count port/counter.
module fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
`ifdef FETCH_STATS_EN
    output logic [15:0]       fetch_count,
`endif
    output logic [ADDR_W-1:0] inst_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     live;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     fifo_cnt;
    logic [PW-1:0]     tag_wr, tag_rd;
    logic [PW-1:0]     fifo_wr, fifo_rd;
    logic [ADDR_W-1:0] tag_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_p1 [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_p1 [DEPTH];

    logic [SW-1:0] kept_slots;
    logic [SW-1:0] inflight;
    logic          issue;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          pop;

    // Request gate and handshake decode. A slot in the FIFO is reserved for
    // every live request, so a kept response always has room to land. A
    // redirect discards any response arriving with it and ignores any pop.
    always_comb begin
        kept_slots     = SW'(live) + SW'(fifo_cnt);
        inflight       = SW'(live) + SW'(drop);
        imem_req_valid = reset && !halt && !redirect_valid &&
                         (kept_slots < SW'(DEPTH)) && (inflight < SW'(DEPTH));
        imem_addr      = pc;
        issue          = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && ((drop != '0) || redirect_valid);
        rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect_valid;
        inst_valid     = (fifo_cnt != '0);
        pop            = inst_valid && inst_ready && !redirect_valid;
        inst_data      = inst_valid ? fifo_data_p1[fifo_rd] : '0;
        inst_pc        = inst_valid ? fifo_pc_p1[fifo_rd] : '0;
    end

    // Control state: fetch address, in-flight accounting, queue pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= '0;
            live     <= '0;
            drop     <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            live     <= '0;
            // Everything still outstanding becomes stale, less the response
            // that completes (and is discarded) in this very cycle.
            drop     <= drop + live - CW'(imem_rsp_valid);
            tag_wr   <= '0;
            tag_rd   <= '0;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (issue) begin
                pc     <= pc + ADDR_W'(1);
                tag_wr <= tag_wr + PW'(1);
            end
            if (rsp_keep) begin
                tag_rd  <= tag_rd + PW'(1);
                fifo_wr <= fifo_wr + PW'(1);
            end
            if (pop) begin
                fifo_rd <= fifo_rd + PW'(1);
            end
            live     <= live + CW'(issue) - CW'(rsp_keep);
            drop     <= drop - CW'(rsp_drop);
            fifo_cnt <= fifo_cnt + CW'(rsp_keep) - CW'(pop);
        end
    end

    // Storage: tag queue and instruction FIFO payload (validity is tracked
    // by the pointers/counters above, so the payload needs no reset).
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_q[tag_wr] <= pc;
        end
        if (rsp_keep) begin
            fifo_data_p1[fifo_wr] <= imem_rsp_data;
            fifo_pc_p1[fifo_wr]   <= tag_q[tag_rd];
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
        end else if (pop) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule
